// File: rtl/dsp_mac_sequencer_if.sv
// Host-side handshakes of the MAC sequencer: job descriptor, operand stream and result.
interface dsp_mac_sequencer_if #(
    parameter int DATA_W = 18,
    parameter int ACC_W  = 48,
    parameter int LEN_W  = 10
);
    logic              job_valid;
    logic              job_ready;
    logic [LEN_W-1:0]  job_len;
    logic              abort;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_a;
    logic [DATA_W-1:0] s_b;
    logic              s_neg;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;

    modport master (
        output job_valid, job_len, abort, s_valid, s_a, s_b, s_neg, res_ready,
        input  job_ready, s_ready, res_valid, res_data
    );

    modport slave (
        input  job_valid, job_len, abort, s_valid, s_a, s_b, s_neg, res_ready,
        output job_ready, s_ready, res_valid, res_data
    );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Streaming MAC sequencer for one DSP48A1 slice: feeds operand pairs, steers
// OPMODE and clock enables per operand so bubbles never touch P, returns final P.
module dsp_mac_sequencer #(
    parameter int DATA_W   = 18,
    parameter int ACC_W    = 48,
    parameter int LEN_W    = 10,
    parameter int PIPE_LAT = 3
) (
    input  logic               CLK,
    input  logic               RSTA,
    dsp_mac_sequencer_if.slave bus,
    output logic [DATA_W-1:0]  dsp_a,
    output logic [DATA_W-1:0]  dsp_b,
    output logic [7:0]         dsp_opmode,
    output logic               dsp_cea,
    output logic               dsp_ceb,
    output logic               dsp_cem,
    output logic               dsp_cep,
    output logic               dsp_rstp,
    input  logic [ACC_W-1:0]   dsp_p,
    output logic               busy
);
    // state | meaning
    // IDLE  | waiting for a job descriptor
    // RUN   | accepting operand pairs
    // DRAIN | waiting for the last product to reach P
    // DONE  | presenting P as the job result
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic v;
        logic neg;
        logic first;
    } tag_t;

    localparam int TAG_D = PIPE_LAT - 1;
    localparam int DCW   = $clog2(PIPE_LAT);

    state_t           state;
    tag_t             tags [TAG_D];
    tag_t             push;
    tag_t             out_tag;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_m1;
    logic [DCW-1:0]   drain_cnt;
    logic             ce;
    logic             zero_len;
    logic             accept;

    // abort wins over a simultaneous handshake, so the pair is dropped
    assign accept = (state == RUN) && bus.s_ready && bus.s_valid && !bus.abort;

    always_comb begin
        push       = '0;
        push.v     = accept;
        push.neg   = accept & bus.s_neg;
        push.first = accept & (cnt == '0);
    end

    assign out_tag    = tags[TAG_D-1];
    assign dsp_a      = bus.s_a;
    assign dsp_b      = bus.s_b;
    assign dsp_cea    = ce;
    assign dsp_ceb    = ce;
    assign dsp_cem    = ce;
    assign dsp_cep    = out_tag.v;
    assign dsp_opmode = out_tag.v ? {out_tag.neg, 3'b000, (out_tag.first ? 2'b00 : 2'b10), 2'b01}
                                  : 8'h00;

    // an empty job's P is only cleared at the end of its first DONE cycle
    assign bus.res_data = zero_len ? '0 : dsp_p;

    always_ff @(posedge CLK or posedge RSTA) begin
        if (RSTA) begin
            state         <= IDLE;
            cnt           <= '0;
            len_m1        <= '0;
            drain_cnt     <= '0;
            for (int i = 0; i < TAG_D; i++) tags[i] <= '0;
            ce            <= 1'b0;
            zero_len      <= 1'b0;
            dsp_rstp      <= 1'b0;
            bus.job_ready <= 1'b1;
            bus.s_ready   <= 1'b0;
            bus.res_valid <= 1'b0;
            busy          <= 1'b0;
        end else if (bus.abort && state != IDLE) begin
            state         <= IDLE;
            cnt           <= '0;
            for (int i = 0; i < TAG_D; i++) tags[i] <= '0;
            ce            <= 1'b0;
            dsp_rstp      <= 1'b0;
            bus.job_ready <= 1'b1;
            bus.s_ready   <= 1'b0;
            bus.res_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            tags[0] <= push;
            for (int i = 1; i < TAG_D; i++) tags[i] <= tags[i-1];
            dsp_rstp <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.job_valid) begin
                        cnt           <= '0;
                        len_m1        <= bus.job_len - LEN_W'(1);
                        bus.job_ready <= 1'b0;
                        busy          <= 1'b1;
                        if (bus.job_len == '0) begin
                            state         <= DONE;
                            dsp_rstp      <= 1'b1;
                            zero_len      <= 1'b1;
                            bus.res_valid <= 1'b1;
                        end else begin
                            state       <= RUN;
                            zero_len    <= 1'b0;
                            ce          <= 1'b1;
                            bus.s_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        cnt <= cnt + LEN_W'(1);
                        if (cnt == len_m1) begin
                            state       <= DRAIN;
                            bus.s_ready <= 1'b0;
                            drain_cnt   <= DCW'(PIPE_LAT - 2);
                        end
                    end
                end
                DRAIN: begin
                    // terminal count lines up with the last tag's P update edge
                    if (drain_cnt == '0) begin
                        state         <= DONE;
                        ce            <= 1'b0;
                        bus.res_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DCW'(1);
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state         <= IDLE;
                        bus.res_valid <= 1'b0;
                        bus.job_ready <= 1'b1;
                        busy          <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: behavioural DSP48A1 slice, job vector table,
// plus hand sequences for abort, mid-drain reset and result back-pressure.
module tb_dsp_mac_sequencer;
    logic        CLK;
    logic        RSTA;
    logic [17:0] dsp_a, dsp_b;
    logic [7:0]  dsp_opmode;
    logic        dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_rstp, busy;
    logic [47:0] dsp_p;

    dsp_mac_sequencer_if bus_if ();

    dsp_mac_sequencer dut (
        .CLK        (CLK),
        .RSTA       (RSTA),
        .bus        (bus_if),
        .dsp_a      (dsp_a),
        .dsp_b      (dsp_b),
        .dsp_opmode (dsp_opmode),
        .dsp_cea    (dsp_cea),
        .dsp_ceb    (dsp_ceb),
        .dsp_cem    (dsp_cem),
        .dsp_cep    (dsp_cep),
        .dsp_rstp   (dsp_rstp),
        .dsp_p      (dsp_p),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // slice model: A1/B1 -> M -> P, post-adder Z +/- X
    logic signed [17:0] a1_q, b1_q;
    logic signed [35:0] m_q;
    logic [47:0]        p_q;
    logic [47:0]        x_v, z_v;

    always_comb begin
        x_v = (dsp_opmode[1:0] == 2'b01) ? {{12{m_q[35]}}, m_q} : 48'h0;
        z_v = (dsp_opmode[3:2] == 2'b10) ? p_q : 48'h0;
    end

    always @(posedge CLK or posedge RSTA) begin
        if (RSTA) begin
            a1_q <= '0; b1_q <= '0; m_q <= '0; p_q <= '0;
        end else begin
            if (dsp_cea) a1_q <= dsp_a;
            if (dsp_ceb) b1_q <= dsp_b;
            if (dsp_cem) m_q <= a1_q * b1_q;
            if (dsp_rstp) p_q <= '0;
            else if (dsp_cep) p_q <= dsp_opmode[7] ? (z_v - x_v) : (z_v + x_v);
        end
    end
    assign dsp_p = p_q;

    int cyc = 0, cep_total = 0, srdy_total = 0, rv_total = 0;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) begin
        if (dsp_cep) cep_total <= cep_total + 1;
        if (bus_if.s_ready) srdy_total <= srdy_total + 1;
        if (bus_if.res_valid) rv_total <= rv_total + 1;
    end

    typedef struct {
        int          len;
        int          gap;
        int          hold;
        int          a [4];
        int          b [4];
        bit [3:0]    neg;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs [9];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int k, input int len, input int gap, input int hold,
                           input int a0, input int a1, input int a2, input int a3,
                           input int b0, input int b1, input int b2, input int b3,
                           input bit [3:0] neg, input longint exp);
        vecs[k].len  = len;
        vecs[k].gap  = gap;
        vecs[k].hold = hold;
        vecs[k].a    = '{a0, a1, a2, a3};
        vecs[k].b    = '{b0, b1, b2, b3};
        vecs[k].neg  = neg;
        vecs[k].exp  = 48'(exp);
    endtask

    // starts #1 after a rising edge, ends #1 after the acceptance edge
    task automatic send_pair(input int a, input int b, input bit neg, output int t_acc);
        int waited = 0;
        bus_if.s_valid = 1'b1;
        bus_if.s_a     = 18'(a);
        bus_if.s_b     = 18'(b);
        bus_if.s_neg   = neg;
        @(negedge CLK);
        while (!bus_if.s_ready && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        check("s_ready_wait", 64'(bus_if.s_ready), 64'(1));
        t_acc = cyc;
        @(posedge CLK); #1;
        bus_if.s_valid = 1'b0;
    endtask

    task automatic start_job(input int len, output int t_job);
        bus_if.job_valid = 1'b1;
        bus_if.job_len   = 10'(len);
        @(negedge CLK);
        check("job_ready_idle", 64'(bus_if.job_ready), 64'(1));
        t_job = cyc;
        @(posedge CLK); #1;
        bus_if.job_valid = 1'b0;
    endtask

    task automatic run_vec(input int k);
        int t_acc, cep0, srdy0, waited, lat, len, exp_srdy;
        len   = vecs[k].len;
        cep0  = cep_total;
        srdy0 = srdy_total;
        start_job(len, t_acc);
        for (int i = 0; i < len; i++) begin
            if (i > 0) repeat (vecs[k].gap) begin @(posedge CLK); #1; end
            send_pair(vecs[k].a[i%4], vecs[k].b[i%4], vecs[k].neg[i%4], t_acc);
        end
        waited = 0;
        @(negedge CLK);
        while (!bus_if.res_valid && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        check("res_valid_seen", 64'(bus_if.res_valid), 64'(1));
        lat = (len > 0) ? 3 : 1;
        check("res_latency", 64'(cyc - t_acc), 64'(lat));
        repeat (vecs[k].hold) begin
            check("res_hold_data", 64'(bus_if.res_data), 64'(vecs[k].exp));
            check("res_hold_job_ready", 64'(bus_if.job_ready), 64'(0));
            @(negedge CLK);
        end
        check("res_data", 64'(bus_if.res_data), 64'(vecs[k].exp));
        bus_if.res_ready = 1'b1;
        @(posedge CLK); #1;
        bus_if.res_ready = 1'b0;
        @(negedge CLK);
        check("res_valid_drop", 64'(bus_if.res_valid), 64'(0));
        check("job_ready_back", 64'(bus_if.job_ready), 64'(1));
        check("cep_pulses", 64'(cep_total - cep0), 64'(len));
        exp_srdy = (len > 0) ? len + vecs[k].gap * (len - 1) : 0;
        check("s_ready_cycles", 64'(srdy_total - srdy0), 64'(exp_srdy));
        @(posedge CLK); #1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_a, rv0;
        RSTA             = 1'b1;
        bus_if.job_valid = 1'b0;
        bus_if.job_len   = '0;
        bus_if.abort     = 1'b0;
        bus_if.s_valid   = 1'b0;
        bus_if.s_a       = '0;
        bus_if.s_b       = '0;
        bus_if.s_neg     = 1'b0;
        bus_if.res_ready = 1'b0;

        //       k len gap hold  a0..a3                     b0..b3                    neg      result
        set_vec(0,  4, 0, 5,    1, 2, 3, 4,                5, 6, 7, 8,               4'b0000, 70);
        set_vec(1,  2, 0, 0,    3, 3, 0, 0,                4, 2, 0, 0,               4'b0010, 6);
        set_vec(2,  2, 0, 0,    3, 3, 0, 0,                4, 2, 0, 0,               4'b0001, -6);
        set_vec(3,  3, 2, 0,   -2, 5, 7, 0,              100, 1, 1, 0,               4'b0000, -188);
        set_vec(4,  0, 0, 0,    0, 0, 0, 0,                0, 0, 0, 0,               4'b0000, 0);
        set_vec(5,  1, 0, 0,   10, 0, 0, 0,               10, 0, 0, 0,               4'b0000, 100);
        set_vec(6,  4, 1, 0, -131072, 131071, -1, 7,  -131072, 131071, 1, -3,        4'b0110, 262123);
        set_vec(7, 1023, 0, 0,  1, 1, 1, 1,                1, 1, 1, 1,               4'b0000, 1023);
        set_vec(8,  1, 0, 0,    1, 0, 0, 0,                1, 0, 0, 0,               4'b0000, 1);

        repeat (3) @(posedge CLK);
        #1 RSTA = 1'b0;
        @(negedge CLK);
        check("rst_job_ready", 64'(bus_if.job_ready), 64'(1));
        check("rst_s_ready", 64'(bus_if.s_ready), 64'(0));
        check("rst_res_valid", 64'(bus_if.res_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ce", 64'({dsp_cea, dsp_ceb, dsp_cem, dsp_cep}), 64'(0));
        check("rst_rstp", 64'(dsp_rstp), 64'(0));
        check("rst_opmode", 64'(dsp_opmode), 64'(0));
        @(posedge CLK); #1;

        for (int k = 0; k < 8; k++) run_vec(k);

        // abort after 2 of 5 pairs, with a handshake offered in the abort cycle
        start_job(5, t_a);
        send_pair(7, 9, 1'b0, t_a);
        send_pair(2, 2, 1'b1, t_a);
        bus_if.abort   = 1'b1;
        bus_if.s_valid = 1'b1;
        bus_if.s_a     = 18'd5;
        @(negedge CLK);
        check("abort_busy_before", 64'(busy), 64'(1));
        @(posedge CLK); #1;
        bus_if.abort   = 1'b0;
        bus_if.s_valid = 1'b0;
        rv0 = rv_total;
        @(negedge CLK);
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_job_ready", 64'(bus_if.job_ready), 64'(1));
        check("abort_s_ready", 64'(bus_if.s_ready), 64'(0));
        check("abort_tags_clear", 64'({dsp_cep, dsp_opmode}), 64'(0));
        repeat (6) @(negedge CLK);
        check("abort_no_result", 64'(rv_total - rv0), 64'(0));
        @(posedge CLK); #1;
        run_vec(8);

        // asynchronous reset in the middle of DRAIN
        start_job(2, t_a);
        send_pair(3, 3, 1'b0, t_a);
        send_pair(4, 4, 1'b0, t_a);
        @(negedge CLK);
        check("drain_busy", 64'(busy), 64'(1));
        check("drain_s_ready", 64'(bus_if.s_ready), 64'(0));
        #2 RSTA = 1'b1;
        #1;
        check("rsta_busy_now", 64'(busy), 64'(0));
        check("rsta_res_valid_now", 64'(bus_if.res_valid), 64'(0));
        check("rsta_ce_now", 64'({dsp_cea, dsp_cep}), 64'(0));
        @(posedge CLK);
        @(posedge CLK); #1;
        RSTA = 1'b0;
        @(negedge CLK);
        check("rsta_job_ready", 64'(bus_if.job_ready), 64'(1));
        check("rsta_res_valid", 64'(bus_if.res_valid), 64'(0));
        @(posedge CLK); #1;
        run_vec(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Controls one DSP48A1 slice as a streaming multiply-accumulate engine.
- Accepts a job descriptor (operand count). Streams operand pairs into the slice's A/B ports using a valid/ready handshake. Drives OPMODE and the clock enables so that bubbles never corrupt the accumulator. Returns the final P value through a valid/ready result port.
- Assumed slice configuration: A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, CARRYINSEL="OPMODE5", BINPUT="DIRECT".

Parameters:
- DATA_W, 18, operand width.
- ACC_W, 48, accumulator/result width.
- LEN_W, 10, width of the job operand count.
- PIPE_LAT, 3, clock edges from operand acceptance to the P update for that operand (A1/B1, M, P).

Ports:
- CLK  in  1  clock.
- RSTA  in  1  reset, asynchronous, active-high.
- job_valid  in  1  job request.
- job_ready  out  1  high in IDLE only.
- job_len  in  LEN_W  number of operand pairs in the job.
- abort  in  1  synchronous job cancel.
- s_valid  in  1  operand pair valid.
- s_ready  out  1  operand pair accepted when s_valid&s_ready.
- s_a  in  DATA_W  multiplicand.
- s_b  in  DATA_W  multiplier.
- s_neg  in  1  subtract this product.
- dsp_a  out  DATA_W  to slice A; equals s_a.
- dsp_b  out  DATA_W  to slice B; equals s_b.
- dsp_opmode  out  8  to slice OPMODE.
- dsp_cea  out  1  slice CEA.
- dsp_ceb  out  1  slice CEB.
- dsp_cem  out  1  slice CEM.
- dsp_cep  out  1  slice CEP.
- dsp_rstp  out  1  synchronous P clear.
- dsp_p  in  ACC_W  slice P.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted.
- res_data  out  ACC_W  job result.
- busy  out  1  state != IDLE.

Behaviour:

States and transitions:
- States: IDLE, RUN, DRAIN, DONE.
- RSTA clears the FSM to IDLE, the counter to 0, and the tag pipeline to 0.
- Reset values of outputs: job_ready=1, s_ready=0, res_valid=0, busy=0, all dsp_ce*=0, dsp_rstp=0, dsp_opmode=0.
- IDLE: on job_valid, latch job_len and clear cnt.
  - If job_len=0, go to DONE and pulse dsp_rstp for one cycle. The result is 0.
  - Otherwise, go to RUN.
- RUN: s_ready=1. Each accepted pair increments cnt and pushes a tag {v=1, neg=s_neg, first=(cnt==0)}. A cycle without acceptance pushes v=0.
  - When the accepted pair has cnt==job_len-1, go to DRAIN.
- DRAIN: s_ready=0. Push v=0 each cycle. Go to DONE on the edge at which the last valid tag receives its P update.
- DONE: res_valid=1 and res_data=dsp_p (pass-through; P is held because dsp_cep=0). On res_ready, go to IDLE.

Slice control:
- dsp_cea = dsp_ceb = dsp_cem = 1 in RUN and DRAIN; 0 otherwise.
- The tag pipeline is PIPE_LAT-1 deep. A tag at index PIPE_LAT-2 describes the operand whose product is currently in M.
- dsp_cep = v of that tag.
- dsp_opmode for that tag:
  - [1:0]=01 (X=M).
  - [3:2]=00 (Z=0) if first, 10 (Z=P) otherwise.
  - [7]=neg.
  - [6:4]=000 (no pre-adder, carry-in 0).
- With v=0, dsp_opmode=0 and dsp_cep=0.
- Result: P = sum over i of (±a_i*b_i), with signs per s_neg. Arithmetic is modulo 2^ACC_W; the slice's carry-out is ignored.

Latency:
- Pair accepted in cycle t → its P update occurs at the end of cycle t+PIPE_LAT-1.
- For the last pair, res_valid is asserted from cycle t+PIPE_LAT.
- Bubbles (s_valid low in RUN) do not change P.

Boundary cases:
- abort in any state except IDLE: next state is IDLE, the tag pipeline is cleared, and no result is produced. P may hold a partial value; the next job's first tag overwrites it (Z=0).
- abort takes priority over a simultaneous handshake or state transition.
- A job_valid arriving while not in IDLE is ignored (job_ready=0).
- job_len at its maximum, 2^LEN_W-1, is supported; cnt must not wrap before the compare.
- RSTA mid-job: all state clears immediately; slice registers are reset externally.

Test Plan:
- job_len=4, a={1,2,3,4}, b={5,6,7,8}, s_neg=0, s_valid held high → res_data=70. res_valid is asserted 3 cycles after the 4th acceptance.
- job_len=2, a={3,3}, b={4,2}, s_neg={0,1} → res_data=6. Repeat with s_neg={1,0} → res_data=-6 (48'hFFFF_FFFF_FFFA).
- job_len=3, a={-2,5,7}, b={100,1,1} with s_valid low for 2 cycles between pairs → res_data=-188. dsp_cep=0 on every bubble cycle.
- job_len=0 → DONE, res_data=0, no s_ready pulse. Then back-to-back job_len=1, a=10, b=10 → 100; the previous P is not accumulated.
- abort in RUN after 2 of 5 pairs → IDLE, no res_valid. Next job_len=1, a=1, b=1 → res_data=1.
- RSTA asserted mid-DRAIN, asynchronously between edges → busy=0 and res_valid=0 immediately; job_ready=1 after release.
- res_ready held low for 5 cycles in DONE → res_data stable and job_ready=0 throughout.
